// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: opcode encoding, flag bit positions and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_NOT = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one step per cycle, WIDTH steps, full 2*WIDTH product.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_nxt;

  // product and done are presented combinationally so the caller captures them on the last step edge
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;
  assign product = acc_nxt;
  assign done    = busy && (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      acc    <= '0;
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result/flags. Define ALU_MUL_EN to build the
// multi-cycle multiplier for opcode 111; otherwise that opcode completes at once flagged illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_V] = v;
    return f;
  endfunction

  alu_op_e          op;
  logic             accept;
  logic             load_op;
  logic [WIDTH:0]   add_w;
  logic [WIDTH-1:0] res_c;
  logic             c_c;
  logic             v_c;
  logic             ill_c;

  assign op     = alu_op_e'(opcode);
  assign accept = in_valid && in_ready;

  always_comb begin
    add_w = '0;
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    ill_c = 1'b0;
    case (op)
      OP_ADD: begin
        add_w = {1'b0, a} + {1'b0, b};
        res_c = add_w[WIDTH-1:0];
        c_c   = add_w[WIDTH];
        v_c   = (a[WIDTH-1] == b[WIDTH-1]) && (res_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = a - b;
        c_c   = (a < b);
        v_c   = (a[WIDTH-1] != b[WIDTH-1]) && (res_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_NOT: res_c = ~a;
      OP_XOR: res_c = a ^ b;
      OP_SHL: res_c = a << b[SHW-1:0];
      default: begin
`ifdef ALU_MUL_EN
        ill_c = 1'b0;
`else
        ill_c = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_e         state;
  alu_state_e         state_nxt;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;

  assign in_ready = !rst && (state == ST_IDLE) && (!out_valid || out_ready);
  assign load_op  = accept && (op != OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && (op == OP_MUL)) begin
          state_nxt = ST_MUL;
          mul_start = 1'b1;
        end
      end
      ST_MUL: if (mul_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end
`else
  assign in_ready = !rst && (!out_valid || out_ready);
  assign load_op  = accept;
`endif

  // ---- output register stage: loads from the single-cycle path or the multiplier's last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      illegal   <= 1'b0;
    end else if (load_op) begin
      out_valid <= 1'b1;
      result    <= res_c;
      flags     <= mk_flags(res_c, c_c, v_c);
      illegal   <= ill_c;
`ifdef ALU_MUL_EN
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_prod[WIDTH-1:0];
      flags     <= mk_flags(mul_prod[WIDTH-1:0], |mul_prod[2*WIDTH-1:WIDTH], 1'b0);
      illegal   <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised self-checking bench for alu_seq (WIDTH=8) against an integer reference model.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [2:0]   opcode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         illegal;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .illegal   (illegal)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic from the opcode rules.
  task automatic ref_alu(input int op, input int av, input int bv,
                         output int r, output int f, output int il, output int lat);
    int s, sa, sb, c, v;
    sa = (av >= 128) ? av - 256 : av;
    sb = (bv >= 128) ? bv - 256 : bv;
    c = 0; v = 0; il = 0; lat = 0; r = 0;
    case (op)
      0: begin s = av + bv; r = s % 256; c = (s > 255) ? 1 : 0;
               s = sa + sb; v = (s > 127 || s < -128) ? 1 : 0; end
      1: begin r = (av - bv + 256) % 256; c = (av < bv) ? 1 : 0;
               s = sa - sb; v = (s > 127 || s < -128) ? 1 : 0; end
      2: r = av & bv;
      3: r = av | bv;
      4: r = 255 - av;
      5: r = av ^ bv;
      6: r = (av << (bv % 8)) % 256;
      default: begin
`ifdef ALU_MUL_EN
        s = av * bv; r = s % 256; c = (s > 255) ? 1 : 0; lat = W;
`else
        r = 0; il = 1;
`endif
      end
    endcase
    f = c * 8 + ((r == 0) ? 4 : 0) + ((r >= 128) ? 2 : 0) + v;
  endtask

  // Issue one op, wait for its result, check it; returns expected values for later hold checks.
  task automatic do_op(input string tag, input int op, input int av, input int bv,
                       output int er, output int ef, output int ei);
    int lat, elat, n;
    ref_alu(op, av, bv, er, ef, ei, elat);
    opcode = 3'(op); a = 8'(av); b = 8'(bv); in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    if (!in_ready) chk({tag, "_accept_timeout"}, 0, 1);
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk({tag, "_busy_ready"}, int'(in_ready), 0);
      step();
      lat++;
    end
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_res"}, int'(result), er);
    chk({tag, "_flags"}, int'(flags), ef);
    chk({tag, "_ill"}, int'(illegal), ei);
  endtask

  initial begin
    int er, ef, ei, c0, c1, c2, op, k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; opcode = '0;
    step(); step();
    chk("rst_ready", int'(in_ready), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_res", int'(result), 0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_ill", int'(illegal), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", int'(in_ready), 1);

    do_op("add", 0, 'hF0, 'h20, er, ef, ei);
    chk("add_c", ef, 4'b1000);
    do_op("sub_borrow", 1, 'h03, 'h05, er, ef, ei);
    chk("sub_borrow_res", er, 'hFE);
    do_op("sub_ovf", 1, 'h80, 'h01, er, ef, ei);
    chk("sub_ovf_v", ef & 1, 1);
    do_op("mul1", 7, 'h0D, 'h0B, er, ef, ei);
    do_op("mul2", 7, 'h20, 'h10, er, ef, ei);
    do_op("shl", 6, 'h81, 'h0B, er, ef, ei);

    // back-pressure: result holds, in_ready low, competing in_valid ignored
    step();
    out_ready = 1'b0;
    do_op("and", 2, 'hCC, 'hAA, er, ef, ei);
    opcode = 3'd0; a = 8'h01; b = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_res", int'(result), 'h88);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_ready", int'(in_ready), 0);
    end
    opcode = 3'd3; a = 8'h0F; b = 8'h30; out_ready = 1'b1;
    #1;
    chk("bp_release_ready", int'(in_ready), 1);
    step();
    in_valid = 1'b0;
    chk("bp_next_valid", int'(out_valid), 1);
    chk("bp_next_res", int'(result), 'h3F);
    step();
    chk("bp_drain", int'(out_valid), 0);

    // back-to-back OR, XOR, NOT
    do_op("b2b_or", 3, 'h12, 'h21, er, ef, ei);  c0 = cyc;
    do_op("b2b_xor", 5, 'hFF, 'h0F, er, ef, ei); c1 = cyc;
    do_op("b2b_not", 4, 'hFF, 'h00, er, ef, ei); c2 = cyc;
    chk("b2b_gap1", c1 - c0, 1);
    chk("b2b_gap2", c2 - c1, 1);
    step();

`ifdef ALU_MUL_EN
    // reset part-way through a multiply
    opcode = 3'd7; a = 8'h0D; b = 8'h0B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("mrst_valid", int'(out_valid), 0);
    chk("mrst_ready", int'(in_ready), 0);
    step();
    rst = 1'b0;
    #1;
    chk("mrst_ready_after", int'(in_ready), 1);
    for (int i = 0; i < 12; i++) begin
      step();
      chk("mrst_no_stale", int'(out_valid), 0);
    end
`endif

    // randomised ops with occasional output stalls
    for (int i = 0; i < 150; i++) begin
      op = int'($urandom_range(0, 7));
      do_op("rnd", op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), er, ef, ei);
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b0;
        k = int'($urandom_range(1, 3));
        for (int j = 0; j < k; j++) begin
          step();
          chk("rnd_hold_res", int'(result), er);
          chk("rnd_hold_flags", int'(flags), ef);
          chk("rnd_hold_valid", int'(out_valid), 1);
        end
        out_ready = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor of the team's 4-bit combinational ALU. Adds configurable operand width, registered result with status flags, valid/ready flow control on both sides, and an optional multi-cycle shift-add multiplier. Sits between an operand-issue stage and a writeback stage. One operation is in flight at a time.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- opcode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT A, 101 XOR, 110 SHL, 111 MUL
- out_valid  output  1  result/flags valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  registered result
- flags  output  4  {C, Z, N, V}, registered with result
- illegal  output  1  registered; set with a result when the opcode is not implemented

## Operation
- FSM states: IDLE, MUL.
- in_ready = !rst && state==IDLE && (!out_valid || out_ready).
- Accept = in_valid && in_ready. Opcode, a and b are sampled only on accept.
- Non-MUL accept: result, flags and illegal load on the same edge. out_valid=1. State stays IDLE.
- MUL accept: state goes to MUL. Multiplicand, multiplier and a zero partial product are loaded. The step counter clears.
- MUL state: one shift-add step per cycle for WIDTH steps. On the last step, result = low WIDTH bits, out_valid=1, and state returns to IDLE.
- Arithmetic is modulo 2^WIDTH.
  - ADD: C = carry out.
  - SUB: C = borrow (a < b unsigned).
  - ADD/SUB: V = signed overflow.
  - SHL: result = a << b[clog2(WIDTH)-1:0]; C=0, V=0.
  - Logic ops and NOT: C=0, V=0.
  - MUL: C = 1 when the upper WIDTH bits of the full product are nonzero; V=0.
- Z = (result==0) and N = result[WIDTH-1] for every op.
- out_valid clears on out_valid && out_ready unless a new result loads on the same edge. In that case out_valid stays 1 with the new data.
- result, flags and illegal hold stable while out_valid && !out_ready.
- in_valid during MUL or during stalled output is ignored; it is not queued.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, flags 0, illegal 0, step counter 0. in_ready reads 0 while rst is high.
- Reset mid-MUL aborts the operation; no result is ever presented for it. in_ready is 1 in the first cycle after rst deasserts.
- Non-MUL latency: accept at edge N, out_valid high after edge N. Throughput is one op per cycle when out_ready=1.
- MUL latency: accept at edge N, out_valid high after edge N+WIDTH. in_ready stays 0 for cycles N+1..N+WIDTH.
- Simultaneous consume and accept in the same cycle is legal; no bubble is inserted.

## Configuration
- ALU_MUL_EN defined: opcode 111 runs the WIDTH-cycle multiplier; illegal is always 0.
- ALU_MUL_EN undefined:
  - The MUL state and multiplier are removed.
  - Opcode 111 completes in one cycle: result 0, flags {0,1,0,0}, illegal=1.
  - in_ready then depends only on output occupancy.

## Structure
- alu_pkg: opcode enum (OP_ADD … OP_MUL), flag bit indices (FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0), FSM state type.
- Sub-module alu_mul_seq, instantiated only under ALU_MUL_EN.
  - Ports: start/done handshake, WIDTH-parameterised, full 2·WIDTH product.
  - Contains the step counter and partial product.
- Top level holds the combinational single-cycle datapath, flag generation, output register and FSM.

## Test plan
- ADD a=0xF0 b=0x20 -> result 0x10, flags C=1 Z=0 N=0 V=0, out_valid the cycle after accept.
- SUB a=0x03 b=0x05 -> 0xFE, C=1 N=1. SUB a=0x80 b=0x01 -> 0x7F, V=1.
- MUL a=0x0D b=0x0B -> 0x8F after exactly 8 cycles with in_ready=0 throughout. MUL a=0x20 b=0x10 -> 0x00, C=1 Z=1.
- Back-pressure: out_ready=0 for 5 cycles after AND 0xCC&0xAA -> result holds 0x88 and in_ready=0. Releasing out_ready consumes it and accepts the next op on the same edge.
- Back-to-back OR, XOR, NOT with out_ready=1 -> three results on three consecutive cycles.
- rst pulsed at step 4 of a MUL -> out_valid 0 immediately, in_ready 1 after deassert, no stale result. Without ALU_MUL_EN, opcode 111 -> result 0, Z=1, illegal=1 in one cycle.
